// File: rtl/hero_write_rx_pkg.sv
// Shared types for the hero write bus and its receiving end.
package hero_write_rx_pkg;

  localparam int HERO_WIDTH        = 64;
  localparam int HERO_RX_MAX_BEATS = 16;

  typedef enum logic [1:0] {
    CYCLE_TYPE_IDLE  = 2'd0,
    CYCLE_TYPE_VALID = 2'd1,
    CYCLE_TYPE_DONE  = 2'd2,
    CYCLE_TYPE_RSVD  = 2'd3
  } cycle_type_e;

  typedef struct packed {
    cycle_type_e           cycle_type;
    logic [HERO_WIDTH-1:0] wdat;
    logic                  clk_en;
    logic [3:0]            another_type_reference;
  } hero_write_t;

  typedef enum logic [1:0] {IDLE, IN_TXN, DROP} HERO_RX_STATE_E;

  typedef struct packed {
    logic                  abort;
    logic                  sop;
    logic                  eop;
    logic [HERO_WIDTH-1:0] data;
  } hero_rx_entry_t;

  // Truncation marker closing a transaction that lost beats.
  function automatic hero_rx_entry_t hero_rx_abort_entry();
    hero_rx_entry_t e;
    e       = '0;
    e.abort = 1'b1;
    e.eop   = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/hero_rx_fifo.sv
// Synchronous FIFO of hero_rx_entry_t; full is based on the registered count only.
module hero_rx_fifo
  import hero_write_rx_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_push,
  input  hero_rx_entry_t i_entry,
  input  logic           i_pop,
  output hero_rx_entry_t o_head,
  output logic           o_full,
  output logic           o_empty,
  output logic [AW:0]    o_count
);

  hero_rx_entry_t r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

  // NOTE: the storage array is not reset; the head is forced to zero while empty instead.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

endmodule

// File: rtl/hero_write_rx.sv
// Hero write bus receiver: frames beats into sop/eop transactions, detects
// overflow and over-long transactions, and closes damaged ones with an abort marker.
module hero_write_rx
  import hero_write_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_BEATS  = HERO_RX_MAX_BEATS,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  hero_write_t           hero_wr_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [HERO_WIDTH-1:0] out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  out_abort,
  output logic [CNT_W-1:0]      txn_count,
  output logic                  err_overflow,
  output logic                  err_protocol,
  input  logic                  err_clr
);

  localparam int BEAT_W = $clog2(MAX_BEATS + 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

  HERO_RX_STATE_E    r_state, w_state_nxt;
  logic [BEAT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;
  logic              r_pend_abort, w_pend_nxt;
  logic              w_qual, w_done, w_full, w_empty;
  logic              w_push, w_set_ovf, w_set_proto, w_txn_inc;
  hero_rx_entry_t    w_push_entry, w_head;
  logic [FCNT_W-1:0] w_fifo_count;
  logic              w_unused;

  assign w_qual   = hero_wr_i.clk_en && (hero_wr_i.cycle_type != CYCLE_TYPE_IDLE);
  assign w_done   = (hero_wr_i.cycle_type == CYCLE_TYPE_DONE);
  assign w_unused = ^{hero_wr_i.another_type_reference, w_fifo_count};

  hero_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_entry (w_push_entry),
    .i_pop   (out_ready),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_count)
  );

  // NOTE: every signal gets a default before the branches so no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_pend_nxt     = r_pend_abort;
    w_push         = 1'b0;
    w_push_entry   = '0;
    w_set_ovf      = 1'b0;
    w_set_proto    = 1'b0;

    // A pending marker owns the push slot; a pending flag implies IDLE or DROP.
    if (r_pend_abort && !w_full) begin
      w_push       = 1'b1;
      w_push_entry = hero_rx_abort_entry();
      w_pend_nxt   = 1'b0;
    end

    if (w_qual) begin
      case (r_state)
        IDLE: begin
          if (w_full || r_pend_abort) begin
            w_set_ovf = 1'b1;
            if (!w_done) w_state_nxt = DROP;
          end else begin
            w_push       = 1'b1;
            w_push_entry = '{abort: 1'b0, sop: 1'b1, eop: w_done, data: hero_wr_i.wdat};
            if (!w_done) begin
              w_state_nxt    = IN_TXN;
              w_beat_cnt_nxt = BEAT_W'(1);
            end
          end
        end
        IN_TXN: begin
          if (r_beat_cnt == BEAT_W'(MAX_BEATS)) begin
            w_set_proto = 1'b1;
            if (!w_full) begin
              w_push       = 1'b1;
              w_push_entry = hero_rx_abort_entry();
            end else begin
              w_pend_nxt = 1'b1;
            end
            w_state_nxt = w_done ? IDLE : DROP;
          end else if (w_full) begin
            w_set_ovf   = 1'b1;
            w_pend_nxt  = 1'b1;
            w_state_nxt = w_done ? IDLE : DROP;
          end else begin
            w_push         = 1'b1;
            w_push_entry   = '{abort: 1'b0, sop: 1'b0, eop: w_done, data: hero_wr_i.wdat};
            w_beat_cnt_nxt = r_beat_cnt + 1'b1;
            if (w_done) w_state_nxt = IDLE;
          end
        end
        DROP: begin
          if (w_done) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end

    w_txn_inc = w_push && w_push_entry.eop && !w_push_entry.abort;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_beat_cnt   <= '0;
      r_pend_abort <= 1'b0;
      txn_count    <= '0;
      err_overflow <= 1'b0;
      err_protocol <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
      r_pend_abort <= w_pend_nxt;
      if (w_txn_inc) txn_count <= txn_count + 1'b1;
      // A new error in the clearing cycle stays visible.
      err_overflow <= w_set_ovf   || (err_overflow && !err_clr);
      err_protocol <= w_set_proto || (err_protocol && !err_clr);
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = w_head.data;
  assign out_sop   = w_head.sop;
  assign out_eop   = w_head.eop;
  assign out_abort = w_head.abort;

endmodule
